// File: rtl/exec_hazard_ctrl.sv
// EX-stage hazard controller for the 5-stage LEGv8 pipeline: operand forwarding,
// load-use / branch / memory-wait stall and flush generation, watchdog and perf counters.
module exec_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rn_D,
  input  logic [4:0]       rm_D,
  input  logic [4:0]       ra_E,
  input  logic [4:0]       rb_E,
  input  logic [4:0]       rd_E,
  input  logic             memRead_E,
  input  logic [4:0]       rd_M,
  input  logic             regWrite_M,
  input  logic             memAcc_M,
  input  logic             dmem_ready,
  input  logic             branch_M,
  input  logic [4:0]       rd_W,
  input  logic             regWrite_W,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_W,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t            state_reg, state_next;
  logic [WC_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;
  logic              load_use;
  logic              hold_all;
  logic              pipe_ctl;
  logic              branch_flush;

  // MEM result beats WB result; XZR is never a real producer
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (regWrite_M && rd_M != 5'd31 && rd_M == src)
      return 2'b10;
    else if (regWrite_W && rd_W != 5'd31 && rd_W == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    forwardA_E = 2'b00;
    forwardB_E = 2'b00;
    if (!reset) begin
      forwardA_E = fwd_sel(ra_E);
      forwardB_E = fwd_sel(rb_E);
    end
  end

  assign load_use = memRead_E && rd_E != 5'd31 && (rd_E == rn_D || rd_E == rm_D);

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    hold_all      = 1'b0;
    pipe_ctl      = 1'b0;
    branch_flush  = 1'b0;
    stall_F       = 1'b0;
    stall_D       = 1'b0;
    stall_E       = 1'b0;
    stall_M       = 1'b0;
    flush_D       = 1'b0;
    flush_E       = 1'b0;
    flush_M       = 1'b0;
    flush_W       = 1'b0;

    if (reset) begin
      state_next    = RUN;
      wait_cnt_next = '0;
      flush_D       = 1'b1;
      flush_E       = 1'b1;
      flush_M       = 1'b1;
      flush_W       = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (memAcc_M && !dmem_ready) begin
            hold_all      = 1'b1;
            state_next    = MEM_WAIT;
            wait_cnt_next = WC_W'(1);
          end else begin
            pipe_ctl = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!dmem_ready) begin
            hold_all      = 1'b1;
            wait_cnt_next = wait_cnt_reg + 1'b1;
            if (wait_cnt_reg == WC_W'(TIMEOUT))
              state_next = ERROR;
          end else begin
            // access completes: pipeline advances and normal hazards apply this cycle
            pipe_ctl      = 1'b1;
            state_next    = RUN;
            wait_cnt_next = '0;
          end
        end
        ERROR:   hold_all   = 1'b1;
        default: state_next = RUN;
      endcase

      if (hold_all) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (pipe_ctl && branch_M) begin
        branch_flush = 1'b1;
        flush_D      = 1'b1;
        flush_E      = 1'b1;
        flush_M      = 1'b1;
      end else if (pipe_ctl && load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (stall_F && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (branch_flush && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign mem_error = (state_reg == ERROR);
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule
